// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: N-input, WIDTH-bit multiplexer with a registered output stage and a
// valid/ready handshake. It sits between N source channels and one consumer.
// The channel comes from sel_i (mode_i=0) or from an internal round-robin scan
// counter (mode_i=1). It is sampled only in the cycle a transfer is accepted.
//
// Parameters:
//   WIDTH  bits per channel
//   N      number of channels (>= 2)
//   SEL_W  select width; must equal $clog2(N)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   in_i           channel k at in_i[k*WIDTH +: WIDTH]
//   sel_i          external channel select (mode_i=0)
//   mode_i         0 = external select, 1 = round-robin scan
//   in_valid_i     source offers a word
//   in_ready_o     block can accept this cycle (combinational)
//   out_o          registered selected data
//   out_ch_o       channel index that produced out_o
//   out_valid_o    out_o/out_ch_o hold a transfer
//   out_ready_i    consumer takes out_o this cycle
//   sel_err_o      last accepted word used sel_i >= N in mode 0
//   out_par_o      even parity of out_o (only with MUX_PARITY_EN defined)
//
// Optional feature macro: MUX_PARITY_EN adds out_par_o.

module mux_nx1_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N*WIDTH-1:0] in_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               mode_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [WIDTH-1:0]   out_o,
    output logic [SEL_W-1:0]   out_ch_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
`ifdef MUX_PARITY_EN
    output logic               out_par_o,
`endif
    output logic               sel_err_o
);

    // Elaboration-time parameter check.
    if (N < 2 || SEL_W != $clog2(N)) begin : gen_param_check
        $error("mux_nx1_reg: need N >= 2 and SEL_W == $clog2(N)");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] scan_q, scan_d;
`ifdef MUX_PARITY_EN
    logic             out_par_q, out_par_d;
`endif

    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] sel_data;
    logic             ch_hit;
    logic             accept;

    // Single-entry pipe register: accept whenever the slot is empty or draining.
    assign in_ready_o = rst_i | ~out_valid_q | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;
    assign ch         = mode_i ? scan_q : sel_i;

    // Compare-and-select rather than a variable part-select, so an out-of-range
    // channel yields zero and unselected channels never reach the output.
    always_comb begin
        sel_data = '0;
        ch_hit   = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (ch == SEL_W'(k)) begin
                sel_data = in_i[k*WIDTH +: WIDTH];
                ch_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        scan_d      = scan_q;
`ifdef MUX_PARITY_EN
        out_par_d   = out_par_q;
`endif
        if (accept) begin
            out_d       = sel_data;
            out_ch_d    = ch;
            out_valid_d = 1'b1;
            // Scan is always in range, so a miss can only come from sel_i.
            sel_err_d   = ~ch_hit;
`ifdef MUX_PARITY_EN
            out_par_d   = ^sel_data;
`endif
            if (mode_i) begin
                scan_d = (scan_q == SEL_W'(N - 1)) ? '0 : scan_q + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_q      <= '0;
`ifdef MUX_PARITY_EN
            out_par_q   <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            scan_q      <= scan_d;
`ifdef MUX_PARITY_EN
            out_par_q   <= out_par_d;
`endif
        end
    end

    assign out_o       = out_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;
    assign sel_err_o   = sel_err_q;
`ifdef MUX_PARITY_EN
    assign out_par_o   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Bench for mux_nx1_reg. Instance A is N=4 and is driven from a vector table.
// Instance B is N=3 and exercises the out-of-range select and the scan wrap.
module tb_mux_nx1_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=4, WIDTH=8
    logic [31:0] a_in;
    logic [1:0]  a_sel, a_ch;
    logic        a_mode, a_iv, a_ordy, a_rdy, a_vld, a_err;
    logic [7:0]  a_out;
`ifdef MUX_PARITY_EN
    logic        a_par;
`endif

    // Instance B: N=3, WIDTH=8
    logic [23:0] b_in;
    logic [1:0]  b_sel, b_ch;
    logic        b_mode, b_iv, b_ordy, b_rdy, b_vld, b_err;
    logic [7:0]  b_out;
`ifdef MUX_PARITY_EN
    logic        b_par;
`endif

    mux_nx1_reg #(.WIDTH(8), .N(4), .SEL_W(2)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (a_in),
        .sel_i       (a_sel),
        .mode_i      (a_mode),
        .in_valid_i  (a_iv),
        .in_ready_o  (a_rdy),
        .out_o       (a_out),
        .out_ch_o    (a_ch),
        .out_valid_o (a_vld),
        .out_ready_i (a_ordy),
`ifdef MUX_PARITY_EN
        .out_par_o   (a_par),
`endif
        .sel_err_o   (a_err)
    );

    mux_nx1_reg #(.WIDTH(8), .N(3), .SEL_W(2)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_i        (b_in),
        .sel_i       (b_sel),
        .mode_i      (b_mode),
        .in_valid_i  (b_iv),
        .in_ready_o  (b_rdy),
        .out_o       (b_out),
        .out_ch_o    (b_ch),
        .out_valid_o (b_vld),
        .out_ready_i (b_ordy),
`ifdef MUX_PARITY_EN
        .out_par_o   (b_par),
`endif
        .sel_err_o   (b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] din;
        logic [1:0]  sel;
        logic        mode;
        logic        iv;
        logic        ordy;
        logic        exp_rdy;
        logic [7:0]  exp_out;
        logic [1:0]  exp_ch;
        logic        exp_vld;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] din, logic [1:0] sel, logic mode, logic iv,
                                logic ordy, logic exp_rdy, logic [7:0] exp_out,
                                logic [1:0] exp_ch, logic exp_vld, logic exp_err);
        vec_t v;
        v.din = din; v.sel = sel; v.mode = mode; v.iv = iv; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_out = exp_out; v.exp_ch = exp_ch;
        v.exp_vld = exp_vld; v.exp_err = exp_err;
        return v;
    endfunction

    localparam logic [31:0] IN0 = 32'h4433_2211;
    localparam logic [31:0] IN1 = 32'hAABB_CCDD;

    task automatic b_step(input logic [1:0] sel, input logic mode);
        b_sel = sel; b_mode = mode; b_iv = 1'b1; b_ordy = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        a_in = '0; a_sel = '0; a_mode = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;
        b_in = {8'h0F, 8'h07, 8'h05}; b_sel = '0; b_mode = 1'b0; b_iv = 1'b0; b_ordy = 1'b0;

        // din, sel, mode, iv, ordy | in_ready before edge | out, ch, valid, err after edge
        // Directed select
        vecs.push_back(mk(IN0, 2'd2, 0, 1, 1, 1, 8'h33, 2'd2, 1, 0));
        // Backpressure: five held cycles with changing in/sel
        vecs.push_back(mk(IN1, 2'd1, 0, 1, 0, 0, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN1, 2'd0, 0, 1, 0, 0, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN1, 2'd3, 1, 1, 0, 0, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN0, 2'd1, 0, 1, 0, 0, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN1, 2'd2, 0, 1, 0, 0, 8'h33, 2'd2, 1, 0));
        // Release: drain and accept on the same edge
        vecs.push_back(mk(IN1, 2'd1, 0, 1, 1, 1, 8'hCC, 2'd1, 1, 0));
        // Drain only; data holds, valid drops
        vecs.push_back(mk(IN0, 2'd0, 0, 0, 1, 1, 8'hCC, 2'd1, 0, 0));
        vecs.push_back(mk(IN0, 2'd3, 0, 0, 0, 1, 8'hCC, 2'd1, 0, 0));
        // Scan wrap
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h11, 2'd0, 1, 0));
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h22, 2'd1, 1, 0));
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h44, 2'd3, 1, 0));
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h11, 2'd0, 1, 0));
        vecs.push_back(mk(IN0, 2'd3, 1, 1, 1, 1, 8'h22, 2'd1, 1, 0));
        // Scan hold across three external-select accepts
        vecs.push_back(mk(IN0, 2'd3, 0, 1, 1, 1, 8'h44, 2'd3, 1, 0));
        vecs.push_back(mk(IN0, 2'd0, 0, 1, 1, 1, 8'h11, 2'd0, 1, 0));
        vecs.push_back(mk(IN0, 2'd1, 0, 1, 1, 1, 8'h22, 2'd1, 1, 0));
        vecs.push_back(mk(IN0, 2'd0, 1, 1, 1, 1, 8'h33, 2'd2, 1, 0));
        vecs.push_back(mk(IN0, 2'd0, 1, 1, 1, 1, 8'h44, 2'd3, 1, 0));
        // Scan mode without accept must not advance
        vecs.push_back(mk(IN0, 2'd0, 1, 0, 1, 1, 8'h44, 2'd3, 0, 0));
        vecs.push_back(mk(IN1, 2'd2, 1, 1, 1, 1, 8'hDD, 2'd0, 1, 0));

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset out", a_out, 0);
        check("reset ch", a_ch, 0);
        check("reset valid", a_vld, 0);
        check("reset err", a_err, 0);
        check("reset in_ready", a_rdy, 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            a_in = vecs[i].din; a_sel = vecs[i].sel; a_mode = vecs[i].mode;
            a_iv = vecs[i].iv; a_ordy = vecs[i].ordy;
            #1;
            check($sformatf("v%0d in_ready", i), a_rdy, vecs[i].exp_rdy);
            @(posedge clk); #1;
            check($sformatf("v%0d out", i), a_out, vecs[i].exp_out);
            check($sformatf("v%0d out_ch", i), a_ch, vecs[i].exp_ch);
            check($sformatf("v%0d out_valid", i), a_vld, vecs[i].exp_vld);
            check($sformatf("v%0d sel_err", i), a_err, vecs[i].exp_err);
`ifdef MUX_PARITY_EN
            check($sformatf("v%0d out_par", i), a_par, ^vecs[i].exp_out);
`endif
        end

        // Bad select on N=3 instance, then recovery
        b_step(2'd3, 1'b0);
        check("bad out", b_out, 0);
        check("bad ch", b_ch, 3);
        check("bad err", b_err, 1);
        check("bad valid", b_vld, 1);
`ifdef MUX_PARITY_EN
        check("bad par", b_par, 0);
`endif
        b_step(2'd1, 1'b0);
        check("good out", b_out, 8'h07);
        check("good ch", b_ch, 1);
        check("good err", b_err, 0);
`ifdef MUX_PARITY_EN
        check("good par", b_par, 1);
`endif
        // N=3 scan wraps at 2; sel=3 is ignored in scan mode
        b_step(2'd3, 1'b1);
        check("b scan0 ch", b_ch, 0);
        check("b scan0 err", b_err, 0);
        b_step(2'd3, 1'b1);
        check("b scan1 ch", b_ch, 1);
        b_step(2'd3, 1'b1);
        check("b scan2 ch", b_ch, 2);
        check("b scan2 out", b_out, 8'h0F);
        b_step(2'd3, 1'b1);
        check("b scan3 ch", b_ch, 0);
        check("b scan3 out", b_out, 8'h05);

        // Async reset mid-transfer while both outputs are holding data
        a_iv = 1'b0; a_ordy = 1'b0; b_iv = 1'b0; b_ordy = 1'b0;
        #1;
        check("pre-rst valid", a_vld, 1);
        rst = 1'b1;
        #1;
        check("rst out", a_out, 0);
        check("rst ch", a_ch, 0);
        check("rst valid", a_vld, 0);
        check("rst err", a_err, 0);
        check("rst in_ready", a_rdy, 1);
        check("rst b valid", b_vld, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Scan counter restarts from 0 after reset
        a_in = IN0; a_mode = 1'b1; a_iv = 1'b1; a_ordy = 1'b1;
        @(posedge clk); #1;
        check("post-rst scan ch", a_ch, 0);
        check("post-rst scan out", a_out, 8'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
